// File: rtl/dipsw_poll_pkg.sv
// Shared definitions for the DIP-switch PIO poll sequencer: FSM states,
// PIO register offsets and timestamp width.
package dipsw_poll_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EDGE_ADDR,
        EDGE_CAP,
        CLEAR,
        DATA_ADDR,
        DATA_CAP,
        EMIT
    } poll_state_t;

    localparam logic [1:0] PIO_DATA = 2'd0;
    localparam logic [1:0] PIO_EDGE = 2'd3;

    localparam int TS_WIDTH = 16;

    // Counter width able to hold interval-1, never narrower than one bit.
    function automatic int timer_width(input int interval);
        return (interval > 1) ? $clog2(interval) : 1;
    endfunction

endpackage

// File: rtl/dipsw_poll_timer.sv
// Loadable down-counter with zero flag; paces the idle gap between PIO polls.
module dipsw_poll_timer #(
    parameter int CW = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic          enable,
    input  logic [CW-1:0] load_value,
    output logic          zero
);

    logic [CW-1:0] count;

    // Reset behaves like a load so the first idle period after reset is full length.
    always_ff @(posedge clk) begin
        if (!reset_n || load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/dipsw_poll_sequencer.sv
// Polls a PIO edge-capture register, clears it, reads switch levels and emits
// a ready/valid event. Define DIPSW_POLL_TIMESTAMP_EN to add the evt_time output.
module dipsw_poll_sequencer
    import dipsw_poll_pkg::*;
#(
    parameter int WIDTH         = 2,
    parameter int POLL_INTERVAL = 1000
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic [1:0]       pio_address,
    output logic             pio_chipselect,
    output logic             pio_write_n,
    output logic [31:0]      pio_writedata,
    input  logic [31:0]      pio_readdata,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [WIDTH-1:0] evt_edges,
    output logic [WIDTH-1:0] evt_level
`ifdef DIPSW_POLL_TIMESTAMP_EN
    ,
    output logic [TS_WIDTH-1:0] evt_time
`endif
);

    localparam int CW = timer_width(POLL_INTERVAL);

    poll_state_t      state;
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] level_q;
    logic [WIDTH-1:0] rd_bits;
    logic             timer_zero;
    logic             unused_readdata;

    assign rd_bits         = pio_readdata[WIDTH-1:0];
    assign unused_readdata = ^pio_readdata;

    // Timer reloads in every non-idle state, so it holds POLL_INTERVAL-1 on IDLE entry.
    dipsw_poll_timer #(
        .CW(CW)
    ) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (state != IDLE),
        .enable    (state == IDLE),
        .load_value(CW'(POLL_INTERVAL - 1)),
        .zero      (timer_zero)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            edge_q         <= '0;
            level_q        <= '0;
            evt_valid      <= 1'b0;
            pio_address    <= PIO_DATA;
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;
            pio_writedata  <= '0;
        end else begin
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;
            pio_writedata  <= '0;
            case (state)
                IDLE: begin
                    if (timer_zero) begin
                        state       <= EDGE_ADDR;
                        pio_address <= PIO_EDGE;
                    end
                end
                EDGE_ADDR: begin
                    state <= EDGE_CAP;
                end
                EDGE_CAP: begin
                    edge_q <= rd_bits;
                    if (rd_bits == '0) begin
                        state       <= IDLE;
                        pio_address <= PIO_DATA;
                    end else begin
                        state          <= CLEAR;
                        pio_chipselect <= 1'b1;
                        pio_write_n    <= 1'b0;
                        pio_writedata  <= '1;
                    end
                end
                CLEAR: begin
                    state       <= DATA_ADDR;
                    pio_address <= PIO_DATA;
                end
                DATA_ADDR: begin
                    state <= DATA_CAP;
                end
                DATA_CAP: begin
                    level_q   <= rd_bits;
                    evt_valid <= 1'b1;
                    state     <= EMIT;
                end
                EMIT: begin
                    // Polling stalls here; edges keep accumulating in the PIO capture.
                    if (evt_ready) begin
                        evt_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    evt_valid   <= 1'b0;
                    pio_address <= PIO_DATA;
                end
            endcase
        end
    end

    assign evt_edges = edge_q;
    assign evt_level = level_q;

`ifdef DIPSW_POLL_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_count;
    logic [TS_WIDTH-1:0] ts_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ts_count <= '0;
            ts_q     <= '0;
        end else begin
            ts_count <= ts_count + 1'b1;
            if (state == EDGE_CAP) begin
                ts_q <= ts_count;
            end
        end
    end

    assign evt_time = ts_q;
`endif

endmodule

// File: tb/tb_dipsw_poll_sequencer.sv
// Directed self-checking bench for dipsw_poll_sequencer with a behavioural PIO
// model (any-edge capture, write-one-to-clear, registered read data).
module tb_dipsw_poll_sequencer;

    localparam int WIDTH = 2;
    localparam int PI    = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic [31:0] pio_readdata = '0;
    logic        evt_valid;
    logic        evt_ready = 1'b1;
    logic [1:0]  evt_edges;
    logic [1:0]  evt_level;
`ifdef DIPSW_POLL_TIMESTAMP_EN
    logic [15:0] evt_time;
`endif

    always #5 clk = ~clk;

    dipsw_poll_sequencer #(
        .WIDTH(WIDTH),
        .POLL_INTERVAL(PI)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pio_address   (pio_address),
        .pio_chipselect(pio_chipselect),
        .pio_write_n   (pio_write_n),
        .pio_writedata (pio_writedata),
        .pio_readdata  (pio_readdata),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .evt_edges     (evt_edges),
        .evt_level     (evt_level)
`ifdef DIPSW_POLL_TIMESTAMP_EN
        ,
        .evt_time      (evt_time)
`endif
    );

    // PIO model: switches drive sw_in, any change sets capture bits.
    logic [1:0] sw_in = 2'b00;
    logic [1:0] sw_prev = 2'b00;
    logic [1:0] cap = 2'b00;

    always @(posedge clk) begin
        if (pio_chipselect && !pio_write_n && (pio_address == 2'd3))
            cap <= (cap & ~pio_writedata[1:0]) | (sw_in ^ sw_prev);
        else
            cap <= cap | (sw_in ^ sw_prev);
        sw_prev <= sw_in;
        if (pio_address == 2'd3)
            pio_readdata <= {30'b0, cap};
        else if (pio_address == 2'd0)
            pio_readdata <= {30'b0, sw_in};
        else
            pio_readdata <= '0;
    end

    int          passed = 0;
    int          total = 0;
    int          ncyc = 0;
    int          rise_cyc = -1;
    int          fall_cyc = -1;
    int          vrise = -1;
    int          wr_cnt = 0;
    int          cs_cnt = 0;
    int          valid_cnt = 0;
    logic [1:0]  prev_addr = 2'd0;
    logic        prev_valid = 1'b0;
    logic [1:0]  wr_addr = 2'd0;
    logic [31:0] wr_data = '0;
    logic [15:0] cyc = '0;
    logic [15:0] cap_ts = '0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One clock: sample outputs 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        ncyc++;
        cyc = reset_n ? cyc + 16'd1 : 16'd0;
        if (pio_chipselect) begin
            cs_cnt++;
            cap_ts = cyc - 16'd1;
        end
        if (pio_chipselect && !pio_write_n) begin
            wr_cnt++;
            wr_addr = pio_address;
            wr_data = pio_writedata;
        end
        if (evt_valid) valid_cnt++;
        if (pio_address == 2'd3 && prev_addr != 2'd3) rise_cyc = ncyc;
        if (pio_address != 2'd3 && prev_addr == 2'd3) fall_cyc = ncyc;
        if (evt_valid && !prev_valid) vrise = ncyc;
        prev_addr  = pio_address;
        prev_valid = evt_valid;
    endtask

    task automatic wait_rise(input int budget, output int at);
        int start;
        start = rise_cyc;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (rise_cyc != start) begin
                at = rise_cyc;
                break;
            end
        end
    endtask

    task automatic wait_fall(input int budget, output int at);
        int start;
        start = fall_cyc;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (fall_cyc != start) begin
                at = fall_cyc;
                break;
            end
        end
    endtask

    task automatic wait_valid(input int budget, output int at);
        int start;
        start = vrise;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (vrise != start) begin
                at = vrise;
                break;
            end
        end
    endtask

    task automatic applyStimulus(input logic [1:0] sw);
        int at;
        wait_fall(20, at);
        checkOutput("idle_entry_seen", (at >= 0), 1'b1);
        sw_in = sw;
    endtask

    initial begin
        int t1, t2, t3, at, wr0, rst_cyc;
        logic stable;

        // Reset state
        repeat (3) tick();
        checkOutput("rst_evt_valid", evt_valid, 1'b0);
        checkOutput("rst_chipselect", pio_chipselect, 1'b0);
        checkOutput("rst_write_n", pio_write_n, 1'b1);
        checkOutput("rst_address", pio_address, 2'd0);
        checkOutput("rst_writedata", pio_writedata, 32'h0);

        // Idle polling with no edges
        reset_n = 1'b1;
        cs_cnt = 0;
        valid_cnt = 0;
        wait_rise(20, t1);
        wait_rise(20, t2);
        wait_rise(20, t3);
        checkOutput("poll_period_a", t2 - t1, 6);
        checkOutput("poll_period_b", t3 - t2, 6);
        checkOutput("idle_no_chipselect", cs_cnt, 0);
        checkOutput("idle_no_valid", valid_cnt, 0);

        // Single edge on bit0, consumer ready
        applyStimulus(2'b01);
        wr_cnt = 0;
        wait_valid(40, at);
        checkOutput("ev1_edges", evt_edges, 2'b01);
        checkOutput("ev1_level", evt_level, 2'b01);
        checkOutput("ev1_latency", at - rise_cyc, 5);
        checkOutput("ev1_write_count", wr_cnt, 1);
        checkOutput("ev1_write_addr", wr_addr, 2'd3);
        checkOutput("ev1_write_data", wr_data, 32'hFFFF_FFFF);
        tick();

        // Backpressure: event held, bit1 toggle merged into the next event
        applyStimulus(2'b00);
        evt_ready = 1'b0;
        wait_valid(40, at);
        checkOutput("ev2_edges", evt_edges, 2'b01);
        checkOutput("ev2_level", evt_level, 2'b00);
        wr0 = wr_cnt;
        stable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (i == 10) sw_in = 2'b10;
            tick();
            if (!evt_valid || evt_edges != 2'b01 || evt_level != 2'b00) stable = 1'b0;
        end
        checkOutput("stall_stable", stable, 1'b1);
        checkOutput("stall_no_write", wr_cnt - wr0, 0);
        evt_ready = 1'b1;
        tick();
        checkOutput("valid_drop_after_accept", evt_valid, 1'b0);
        wait_valid(40, at);
        checkOutput("ev3_edges", evt_edges, 2'b10);
        checkOutput("ev3_level", evt_level, 2'b10);
        tick();

        // Reset asserted while the clear write is on the bus
        applyStimulus(2'b11);
        for (int i = 0; i < 30 && !pio_chipselect; i++) tick();
        checkOutput("clear_reached", pio_chipselect, 1'b1);
        reset_n = 1'b0;
        tick();
        rst_cyc = ncyc;
        checkOutput("midrst_chipselect", pio_chipselect, 1'b0);
        checkOutput("midrst_write_n", pio_write_n, 1'b1);
        checkOutput("midrst_evt_valid", evt_valid, 1'b0);
        checkOutput("midrst_address", pio_address, 2'd0);
        reset_n = 1'b1;
        wait_rise(20, at);
        checkOutput("midrst_idle_interval", at - rst_cyc, 4);

`ifdef DIPSW_POLL_TIMESTAMP_EN
        // Timestamps across the 16-bit wrap
        for (int i = 0; i < 70000 && cyc < 16'hFFF0; i++) tick();
        applyStimulus(2'b10);
        wait_valid(40, at);
        checkOutput("ts_ev_a", evt_time, cap_ts);
        t1 = int'(evt_time);
        tick();
        for (int i = 0; i < 100 && cyc >= 16'h8000; i++) tick();
        applyStimulus(2'b00);
        wait_valid(40, at);
        checkOutput("ts_ev_b", evt_time, cap_ts);
        t2 = int'(evt_time);
        checkOutput("ts_wrapped", (t2 < t1), 1'b1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dipsw_poll_sequencer.md
DIPSW_POLL_SEQUENCER -- requirements
Module: dipsw_poll_sequencer

Interface
REQ-001 Parameter: WIDTH, default 2, number of switch bits serviced.
REQ-002 Parameter: POLL_INTERVAL, default 1000, clk cycles from poll completion to next poll start (minimum 1).
REQ-003 Port: clk  in  1  sole clock; all logic on rising edge.
REQ-004 Port: reset_n  in  1  reset, synchronous and active-low.
REQ-005 Port: pio_address  out  2  PIO register select (0 = data, 3 = edge capture).
REQ-006 Port: pio_chipselect  out  1  PIO access strobe.
REQ-007 Port: pio_write_n  out  1  PIO write strobe, active-low.
REQ-008 Port: pio_writedata  out  32  PIO write data.
REQ-009 Port: pio_readdata  in  32  PIO read data, registered, valid one cycle after address presented.
REQ-010 Port: evt_valid  out  1  switch event available.
REQ-011 Port: evt_ready  in  1  consumer accepts event.
REQ-012 Port: evt_edges  out  WIDTH  edge-capture bits of the event.
REQ-013 Port: evt_level  out  WIDTH  switch levels read after clearing the capture.

Function
REQ-014 FSM states SHALL be IDLE, EDGE_ADDR, EDGE_CAP, CLEAR, DATA_ADDR, DATA_CAP, EMIT.
REQ-015 IDLE: down-counter loaded with POLL_INTERVAL-1 on entry; at zero go to EDGE_ADDR.
REQ-016 EDGE_ADDR: pio_address=3, chipselect=0, write_n=1; next EDGE_CAP.
REQ-017 EDGE_CAP: latch pio_readdata[WIDTH-1:0] into edge register; if zero go to IDLE (no event), else CLEAR.
REQ-018 CLEAR: exactly one cycle with pio_address=3, chipselect=1, write_n=0, writedata=all ones; next DATA_ADDR.
REQ-019 DATA_ADDR: pio_address=0, strobes inactive; next DATA_CAP.
REQ-020 DATA_CAP: latch pio_readdata[WIDTH-1:0] into level register; next EMIT.
REQ-021 EMIT: evt_valid=1, evt_edges/evt_level held stable; on evt_valid&&evt_ready go to IDLE.
REQ-022 Outside CLEAR, pio_chipselect=0, pio_write_n=1, pio_writedata=0.
REQ-023 Poll latency: edge present in PIO capture at IDLE expiry yields evt_valid exactly 5 cycles later.
REQ-024 Backpressure: polling SHALL stall in EMIT; new edges accumulate in PIO capture and are merged into the next event (no loss of edge indication).
REQ-025 An edge arriving between EDGE_CAP and CLEAR is cleared unreported; accepted, documented limitation.
REQ-026 evt_valid SHALL never deassert without handshake except on reset.

Reset
REQ-027 reset_n low at a rising edge: state=IDLE, counter=POLL_INTERVAL-1, edge/level registers=0, evt_valid=0, pio_chipselect=0, pio_write_n=1, pio_address=0, pio_writedata=0.
REQ-028 Reset mid-operation (including CLEAR or EMIT) SHALL abort the transaction and drop any pending event.

Configuration
REQ-029 Macro DIPSW_POLL_TIMESTAMP_EN: when defined, add output evt_time[15:0] from a free-running 16-bit counter (reset 0, wraps 0xFFFF->0) captured in EDGE_CAP, held through EMIT.
REQ-030 Without DIPSW_POLL_TIMESTAMP_EN: no evt_time port, no counter; all other behaviour identical.

Structure
REQ-031 Shared package dipsw_poll_pkg SHALL hold FSM state enum, PIO register offsets (DATA=0, EDGE=3), timestamp width 16.
REQ-032 Sub-module dipsw_poll_timer (loadable down-counter with zero flag) SHALL implement the IDLE interval.

Verification
REQ-033 POLL_INTERVAL=4, no edges: EDGE_ADDR/EDGE_CAP repeat every 6 cycles, chipselect never asserted, evt_valid stays 0.
REQ-034 PIO edge=2'b01, level=2'b01, evt_ready=1: one CLEAR write to address 3, evt_edges=01, evt_level=01, 5 cycles after IDLE expiry.
REQ-035 evt_ready=0 for 100 cycles, further toggle on bit1 during stall: event held stable; after accept, next event evt_edges=10.
REQ-036 reset_n low during CLEAR: next cycle chipselect=0, write_n=1, evt_valid=0, state IDLE.
REQ-037 DIPSW_POLL_TIMESTAMP_EN defined, counter pre-driven to 0xFFFE: two events captured across wrap, evt_time increments modulo 2^16.
